// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: bit-serial unsigned magnitude comparator controller.
// Walks two captured operands MSB-first through a single one_bit_comp cell,
// carrying the less/greater/equal chain in registers, with optional early
// termination at the first differing bit.

module one_bit_comp (
    input  logic a,
    input  logic b,
    input  logic lin,
    input  logic gin,
    input  logic eqin,
    output logic lout,
    output logic gout,
    output logic eqout
);
    // A decision made at a higher bit propagates; otherwise this bit decides.
    assign lout  = lin | (eqin & ~a &  b);
    assign gout  = gin | (eqin &  a & ~b);
    assign eqout = eqin & ~(a ^ b);
endmodule

module serial_comp_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             l_q;
    logic             g_q;
    logic             e_q;
    logic             lout;
    logic             gout;
    logic             eqout;
    logic             terminal;

    one_bit_comp u_cell (
        .a     (a_q[idx]),
        .b     (b_q[idx]),
        .lin   (l_q),
        .gin   (g_q),
        .eqin  (e_q),
        .lout  (lout),
        .gout  (gout),
        .eqout (eqout)
    );

    // The LSB always ends the walk; with early exit, so does the first difference.
    assign terminal = (idx == '0) || (EARLY_EXIT && !eqout);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: abort and terminal bit both return to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (abort || terminal) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: busy is a direct decode of the state flop.
    always_comb begin
        busy = (state == RUN);
    end

    // Operand capture, bit walk, chain registers and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            idx  <= '0;
            l_q  <= 1'b0;
            g_q  <= 1'b0;
            e_q  <= 1'b1;
            lt   <= 1'b0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        idx <= IW'(WIDTH - 1);
                        l_q <= 1'b0;
                        g_q <= 1'b0;
                        e_q <= 1'b1;
                        lt  <= 1'b0;
                        gt  <= 1'b0;
                        eq  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Cancelled comparison: all flags low marks the result invalid.
                        lt <= 1'b0;
                        gt <= 1'b0;
                        eq <= 1'b0;
                    end else begin
                        l_q <= lout;
                        g_q <= gout;
                        e_q <= eqout;
                        if (terminal) begin
                            lt   <= lout;
                            gt   <= gout;
                            eq   <= eqout;
                            done <= 1'b1;
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Testbench for serial_comp_ctrl: two instances (early exit on / off) share
// one randomized + directed stimulus stream. A transaction-level model derives
// each result and its latency from the operands; a monitor compares outputs.

module tb_serial_comp_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [2:0] flags;   // {lt, gt, eq}
        int         lat;
        int         t0;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   busy_v;
    logic [1:0]   done_v;
    logic [1:0]   lt_v;
    logic [1:0]   gt_v;
    logic [1:0]   eq_v;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state, index 0 = early exit enabled, index 1 = disabled.
    exp_t       q0[$];
    exp_t       q1[$];
    bit   [1:0] m_busy = '0;
    bit   [1:0] m_done = '0;
    logic [2:0] m_flags [2];
    logic [2:0] m_res   [2];
    int         m_rem   [2];

    serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .lt(lt_v[0]), .gt(gt_v[0]), .eq(eq_v[0])
    );

    serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .lt(lt_v[1]), .gt(gt_v[1]), .eq(eq_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from start acceptance to the terminal edge.
    function automatic int lat_of(bit ee, logic [W-1:0] x, logic [W-1:0] y);
        if (!ee || x == y) return W;
        for (int k = W - 1; k >= 0; k--) begin
            if (x[k] != y[k]) return W - k;
        end
        return W;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: transaction view of accept / abort / complete.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_busy = '0;
            m_done = '0;
            for (int i = 0; i < 2; i++) begin
                m_flags[i] = 3'b000;
                m_res[i]   = 3'b000;
                m_rem[i]   = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (start) begin
                        e.flags = {a < b, a > b, a == b};
                        e.lat   = lat_of(i == 0, a, b);
                        e.t0    = cyc;
                        if (i == 0) q0.push_back(e);
                        else        q1.push_back(e);
                        m_busy[i]  = 1'b1;
                        m_rem[i]   = e.lat;
                        m_res[i]   = e.flags;
                        m_flags[i] = 3'b000;
                    end
                end else if (abort) begin
                    m_busy[i]  = 1'b0;
                    m_flags[i] = 3'b000;
                    if (i == 0) void'(q0.pop_back());
                    else        void'(q1.pop_back());
                end else begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_busy[i]  = 1'b0;
                        m_done[i]  = 1'b1;
                        m_flags[i] = m_res[i];
                    end
                end
            end
        end
    end

    // Monitor: compares every cycle and right after reset assertion.
    initial begin
        exp_t e;
        int   depth;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy[%0d]", i), int'(busy_v[i]), int'(m_busy[i]));
                check($sformatf("done[%0d]", i), int'(done_v[i]), int'(m_done[i]));
                check($sformatf("flags[%0d]", i), int'({lt_v[i], gt_v[i], eq_v[i]}), int'(m_flags[i]));
                depth = (i == 0) ? q0.size() : q1.size();
                if (done_v[i]) begin
                    check($sformatf("sb_pending[%0d]", i), depth, 1);
                    if (depth > 0) begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("sb_result[%0d]", i), int'({lt_v[i], gt_v[i], eq_v[i]}), int'(e.flags));
                        check($sformatf("sb_latency[%0d]", i), cyc - e.t0, e.lat);
                    end
                end else if (m_done[i] && depth > 0) begin
                    if (i == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    end

    task automatic drive(bit s, bit ab, logic [W-1:0] x, logic [W-1:0] y);
        start = s;
        abort = ab;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
    endtask

    // Idle with scrambled operands until both instances are free.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_v != 2'b00) begin
            drive(1'b0, 1'b0, W'($urandom), W'($urandom));
            n++;
            if (n > 40) begin
                $display("FAIL wait_idle: busy=%b after 40 cycles, required 00", busy_v);
                $fatal(1, "timeout");
            end
        end
        drive(1'b0, 1'b0, W'($urandom), W'($urandom));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           m;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset in the middle of a comparison.
        drive(1'b1, 1'b0, 8'h5A, 8'h5B);
        repeat (3) drive(1'b0, 1'b0, 8'h5A, 8'h5B);
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h5A, 8'h5B);
        rst_n = 1'b1;
        repeat (10) drive(1'b0, 1'b0, 8'h5A, 8'h5B);

        // Equal operands walk all bits.
        drive(1'b1, 1'b0, 8'hA5, 8'hA5);
        wait_idle();

        // MSB difference: one cycle with early exit, full walk without.
        drive(1'b1, 1'b0, 8'h80, 8'h7F);
        wait_idle();

        // LSB difference with operands changing while busy.
        drive(1'b1, 1'b0, 8'h10, 8'h11);
        wait_idle();

        // Abort at the fourth cycle, then a clean comparison.
        drive(1'b1, 1'b0, 8'h01, 8'h02);
        repeat (3) drive(1'b0, 1'b0, 8'h01, 8'h02);
        drive(1'b0, 1'b1, 8'h01, 8'h02);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h03, 8'h02);
        wait_idle();

        // Start held high: back-to-back, and ignored while busy.
        drive(1'b1, 1'b0, 8'hFF, 8'h00);
        repeat (12) drive(1'b1, 1'b0, 8'h00, 8'hFF);
        wait_idle();

        // Randomized traffic with near-equal operands and sporadic aborts.
        for (int n = 0; n < 1500; n++) begin
            x = W'($urandom);
            m = $urandom_range(0, 3);
            case (m)
                0:       y = x;
                1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, x, y);
        end
        wait_idle();
        repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
